// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the PC/IMEM stage and decode; holds {PC+4, instr}.
// Latency: an entry pushed into an empty queue appears at the head one cycle after its push edge.
// Backpressure: Fetch_Stall holds the PC while full; a pop on a full cycle frees the slot for the next cycle.
module if_fetch_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             PC_In,
    input  logic [N-1:0]             Instr_In,
    input  logic                     Flush,
    input  logic                     Decode_Ready,
    output logic                     Fetch_Stall,
    output logic [N-1:0]             IFID_PC4,
    output logic [N-1:0]             IFID_Instr,
    output logic                     IFID_Valid,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  pc4_mem   [DEPTH];
    logic [N-1:0]  instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    // Full is judged on the registered count only, so a pop in the same cycle
    // cannot open a slot until the following edge.
    assign full        = (count == CW'(DEPTH));
    assign Fetch_Stall = full && !Flush;
    assign push        = !full && !Flush;
    assign pop         = (count != '0) && Decode_Ready && !Flush;

    assign Count       = count;
    assign IFID_Valid  = (count != '0);
    assign IFID_PC4    = IFID_Valid ? pc4_mem[rd_ptr]   : '0;
    assign IFID_Instr  = IFID_Valid ? instr_mem[rd_ptr] : '0;

    // Occupancy and pointers; flush redirects fetch and beats push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (Flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable through the valid-gated head,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc4_mem[wr_ptr]   <= PC_In + N'(4);
            instr_mem[wr_ptr] <= Instr_In;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue with a queue-based scoreboard model.
// Inputs driven and outputs sampled on the falling edge; state changes on the rising edge.
// Directed scenarios followed by a short randomized run.
module tb_if_fetch_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           PC_In;
    logic [N-1:0]           Instr_In;
    logic                   Flush;
    logic                   Decode_Ready;
    logic                   Fetch_Stall;
    logic [N-1:0]           IFID_PC4;
    logic [N-1:0]           IFID_Instr;
    logic                   IFID_Valid;
    logic [$clog2(DEPTH):0] Count;

    int checks = 0;
    int passes = 0;

    logic [2*N-1:0] exp_q[$];

    if_fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .PC_In        (PC_In),
        .Instr_In     (Instr_In),
        .Flush        (Flush),
        .Decode_Ready (Decode_Ready),
        .Fetch_Stall  (Fetch_Stall),
        .IFID_PC4     (IFID_PC4),
        .IFID_Instr   (IFID_Instr),
        .IFID_Valid   (IFID_Valid),
        .Count        (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*N-1:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : '0;
    endfunction

    // One clock of stimulus; called at a falling edge, returns at the next falling edge.
    task automatic cycle(input logic [N-1:0] pc, input logic [N-1:0] ins,
                         input logic fl, input logic rdy);
        logic do_pop;
        logic do_push;
        PC_In        = pc;
        Instr_In     = ins;
        Flush        = fl;
        Decode_Ready = rdy;
        do_pop  = (exp_q.size() != 0) && rdy && !fl;
        do_push = (exp_q.size() != DEPTH) && !fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({pc + 32'd4, ins});
        end
        @(negedge clk);
        Decode_Ready = 1'b0;
        Flush        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; Flush = 1'b0; Decode_Ready = 1'b0;
        PC_In = 32'h1234_5678; Instr_In = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        checks++; if (Count !== '0) $display("FAIL reset_count: got %0d want 0", Count); else passes++;
        checks++; if (IFID_Valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", IFID_Valid); else passes++;
        checks++; if (IFID_PC4 !== 32'h0) $display("FAIL reset_pc4: got %h want 0", IFID_PC4); else passes++;
        checks++; if (IFID_Instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", IFID_Instr); else passes++;
        checks++; if (Fetch_Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", Fetch_Stall); else passes++;
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_empty_fill();
        cycle(32'h0040_0000, 32'h2008_0005, 1'b0, 1'b0);
        checks++; if (IFID_Valid !== 1'b1) $display("FAIL fill_valid: got %b want 1", IFID_Valid); else passes++;
        checks++; if (IFID_PC4 !== 32'h0040_0004) $display("FAIL fill_pc4: got %h want 00400004", IFID_PC4); else passes++;
        checks++; if (IFID_Instr !== 32'h2008_0005) $display("FAIL fill_instr: got %h want 20080005", IFID_Instr); else passes++;
        checks++; if (Count !== 3'd1) $display("FAIL fill_count: got %0d want 1", Count); else passes++;
    endtask

    task automatic test_full();
        for (int i = 1; i < 4; i++) cycle(32'h0040_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        checks++; if (Count !== 3'd4) $display("FAIL full_count: got %0d want 4", Count); else passes++;
        checks++; if (Fetch_Stall !== 1'b1) $display("FAIL full_stall: got %b want 1", Fetch_Stall); else passes++;
        // Fifth word must be dropped and the head must hold while decode is not ready.
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0040_0010, 32'hBAD0_0000, 1'b0, 1'b0);
            checks++; if (IFID_PC4 !== 32'h0040_0004) $display("FAIL full_hold_pc4: got %h want 00400004", IFID_PC4); else passes++;
        end
        checks++; if (Count !== 3'd4) $display("FAIL full_hold_count: got %0d want 4", Count); else passes++;
    endtask

    task automatic test_full_pop();
        cycle(32'h0040_0010, 32'hBAD0_0001, 1'b0, 1'b1);
        checks++; if (Count !== 3'd3) $display("FAIL fullpop_count: got %0d want 3", Count); else passes++;
        checks++; if (IFID_PC4 !== 32'h0040_0008) $display("FAIL fullpop_pc4: got %h want 00400008", IFID_PC4); else passes++;
        checks++; if (Fetch_Stall !== 1'b0) $display("FAIL fullpop_stall: got %b want 0", Fetch_Stall); else passes++;
        checks++; if ({IFID_PC4, IFID_Instr} !== exp_head()) $display("FAIL fullpop_head: got %h want %h", {IFID_PC4, IFID_Instr}, exp_head()); else passes++;
    endtask

    task automatic test_flush();
        // Refill to full so the flush-time stall release is meaningful.
        cycle(32'h0040_0010, 32'hC000_0004, 1'b0, 1'b0);
        checks++; if (Fetch_Stall !== 1'b1) $display("FAIL preflush_stall: got %b want 1", Fetch_Stall); else passes++;
        Flush = 1'b1; Decode_Ready = 1'b1;
        #1;
        checks++; if (Fetch_Stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", Fetch_Stall); else passes++;
        cycle(32'h0050_0000, 32'hC000_0005, 1'b1, 1'b1);
        checks++; if (Count !== '0) $display("FAIL flush_count: got %0d want 0", Count); else passes++;
        checks++; if (IFID_Valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", IFID_Valid); else passes++;
        checks++; if (IFID_Instr !== 32'h0) $display("FAIL flush_instr: got %h want 0", IFID_Instr); else passes++;
        checks++; if (IFID_PC4 !== 32'h0) $display("FAIL flush_pc4: got %h want 0", IFID_PC4); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] prev;
        cycle(32'h0040_0000, 32'h1000_0000, 1'b0, 1'b1);
        prev = IFID_PC4;
        for (int i = 1; i <= 10; i++) begin
            checks++; if ({IFID_PC4, IFID_Instr} !== exp_head()) $display("FAIL stream_head[%0d]: got %h want %h", i, {IFID_PC4, IFID_Instr}, exp_head()); else passes++;
            cycle(32'h0040_0000 + 32'(4*i), 32'h1000_0000 + 32'(i), 1'b0, 1'b1);
            checks++; if (Count !== 3'd1) $display("FAIL stream_count[%0d]: got %0d want 1", i, Count); else passes++;
            checks++; if (IFID_PC4 !== prev + 32'd4) $display("FAIL stream_step[%0d]: got %h want %h", i, IFID_PC4, prev + 32'd4); else passes++;
            prev = IFID_PC4;
        end
        checks++; if (IFID_PC4 !== 32'h0040_002C) $display("FAIL stream_last: got %h want 0040002c", IFID_PC4); else passes++;
    endtask

    task automatic test_async_reset();
        cycle(32'h0, 32'h0, 1'b1, 1'b0);
        cycle(32'h0060_0000, 32'hD000_0000, 1'b0, 1'b0);
        cycle(32'h0060_0004, 32'hD000_0001, 1'b0, 1'b0);
        checks++; if (Count !== 3'd2) $display("FAIL prereset_count: got %0d want 2", Count); else passes++;
        PC_In = 32'h0070_0000; Instr_In = 32'hE000_0000; Decode_Ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (Count !== '0) $display("FAIL areset_count: got %0d want 0", Count); else passes++;
        checks++; if ({IFID_Valid, IFID_PC4, IFID_Instr} !== '0) $display("FAIL areset_outputs: got %h want 0", {IFID_Valid, IFID_PC4, IFID_Instr}); else passes++;
        @(posedge clk);
        @(negedge clk);
        checks++; if (Count !== '0) $display("FAIL areset_inflight: got %0d want 0", Count); else passes++;
        reset = 1'b1;
        Decode_Ready = 1'b0;
        exp_q.delete();
        cycle(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++; if (IFID_PC4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", IFID_PC4); else passes++;
        checks++; if (IFID_Valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", IFID_Valid); else passes++;
        checks++; if (IFID_Instr !== 32'hDEAD_BEEF) $display("FAIL wrap_instr: got %h want deadbeef", IFID_Instr); else passes++;
    endtask

    task automatic test_random();
        logic          fl;
        logic          rdy;
        logic [N-1:0]  pc;
        logic [N-1:0]  ins;
        for (int i = 0; i < 200; i++) begin
            fl  = ($urandom_range(0, 15) == 0);
            rdy = 1'($urandom_range(0, 2) == 0);
            pc  = {$urandom, 2'b00} >> 0;
            pc  = {pc[N-1:2], 2'b00};
            ins = $urandom;
            Flush = fl; Decode_Ready = rdy; PC_In = pc; Instr_In = ins;
            #1;
            checks++; if (Fetch_Stall !== ((exp_q.size() == DEPTH) && !fl)) $display("FAIL rand_stall[%0d]: got %b want %b", i, Fetch_Stall, (exp_q.size() == DEPTH) && !fl); else passes++;
            cycle(pc, ins, fl, rdy);
            checks++; if (Count !== 3'(exp_q.size())) $display("FAIL rand_count[%0d]: got %0d want %0d", i, Count, exp_q.size()); else passes++;
            checks++; if ({IFID_Valid, IFID_PC4, IFID_Instr} !== {exp_q.size() != 0, exp_head()}) $display("FAIL rand_head[%0d]: got %h want %h", i, {IFID_Valid, IFID_PC4, IFID_Instr}, {exp_q.size() != 0, exp_head()}); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_empty_fill();
        test_full();
        test_full_pop();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter N, default 32, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PC_In  input  N  PC of the instruction currently fetched; driven by the PC register's PCValue.
REQ-006 SHALL have port Instr_In  input  N  instruction word read from instruction memory at PC_In.
REQ-007 SHALL have port Flush  input  1  active-high; discards all queued entries on taken branch or jump.
REQ-008 SHALL have port Decode_Ready  input  1  active-high; decode stage accepts the head entry this cycle.
REQ-009 SHALL have port Fetch_Stall  output  1  active-high hold; drives the PC register's PC_Write (1 = hold PC).
REQ-010 SHALL have port IFID_PC4  output  N  PC+4 of the head entry.
REQ-011 SHALL have port IFID_Instr  output  N  instruction of the head entry.
REQ-012 SHALL have port IFID_Valid  output  1  head entry present.
REQ-013 SHALL have port Count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL store per entry {PC_In+4, Instr_In}; the +4 is modulo 2^N (0xFFFFFFFC -> 0x00000000).
REQ-015 SHALL assert Fetch_Stall combinationally exactly when Count == DEPTH and Flush == 0.
REQ-016 SHALL push at a rising edge iff Fetch_Stall == 0 and Flush == 0.
REQ-017 SHALL pop at a rising edge iff IFID_Valid == 1, Decode_Ready == 1 and Flush == 0.
REQ-018 SHALL support a simultaneous push and pop in one cycle: Count unchanged, both pointers advance.
REQ-019 SHALL NOT push when full, even if a pop occurs in the same cycle; the freed slot is filled no earlier than the next cycle.
REQ-020 SHALL present a pushed entry on the outputs one cycle after its push edge when the queue was empty (latency 1).
REQ-021 SHALL drive IFID_PC4, IFID_Instr and IFID_Valid from registered storage and pointers only; no combinational path from Instr_In to the outputs.
REQ-022 SHALL drive IFID_Valid = (Count != 0).
REQ-023 SHALL drive IFID_PC4 and IFID_Instr to 0 (NOP) when IFID_Valid == 0.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL, on Flush == 1 at an edge, set Count to 0 and both pointers to 0; Flush takes priority over push and pop.
REQ-026 SHALL deassert Fetch_Stall while Flush == 1, so the redirected PC loads in the same cycle.
REQ-027 SHALL hold the same head entry on the outputs while Decode_Ready == 0.
REQ-028 SHALL hold Count and all stored entries while there is no push, no pop and no flush.
REQ-029 SHALL treat occupancy states as EMPTY (Count 0), PARTIAL and FULL (Count DEPTH), with transitions only through REQ-016..REQ-025.

Reset
REQ-030 SHALL, while reset == 0, immediately and asynchronously force Count = 0, pointers = 0, IFID_Valid = 0, IFID_PC4 = 0, IFID_Instr = 0 and Fetch_Stall = 0.
REQ-031 SHALL discard any in-flight push or pop coinciding with reset assertion.
REQ-032 SHALL accept its first push at the first rising edge after reset deasserts.

Verification
REQ-033 Empty fill: reset release; PC_In = 0x00400000, Instr_In = 0x20080005, Decode_Ready = 0 -> next cycle IFID_Valid = 1, IFID_PC4 = 0x00400004, IFID_Instr = 0x20080005, Count = 1.
REQ-034 Full: PC_In = 0x00400000..0x0040000C, Decode_Ready = 0 for 4 cycles -> Count = 4, Fetch_Stall = 1; the 5th word is not stored; the head is still 0x00400004.
REQ-035 Full with pop: from the full state, Decode_Ready = 1 for one cycle -> Count = 3, head IFID_PC4 = 0x00400008, Fetch_Stall = 0 next cycle, with no push on the pop edge.
REQ-036 Flush: Count = 3, then Flush = 1 with Decode_Ready = 1 -> next cycle Count = 0, IFID_Valid = 0, IFID_Instr = 0; Fetch_Stall = 0 during the flush cycle.
REQ-037 Streaming wrap: Decode_Ready = 1 for 10 cycles with sequential PCs from 0x00400000 -> Count stays 1; IFID_PC4 increments by 4 each cycle through pointer wrap; no entry is lost or duplicated.
REQ-038 Async reset: reset = 0 asserted mid-cycle with Count = 2 -> outputs zero before the next clk edge; PC_In = 0xFFFFFFFC pushed after release -> IFID_PC4 = 0x00000000.
